// File: rtl/bch_pkg.sv
// ============================================================================
//  Module      : bch_pkg
//  Description : Code geometry and GF(2^6) arithmetic for the BCH(44,32) codec
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bch_pkg;

    localparam int          N         = 44;
    localparam int          K         = 32;
    localparam int          P         = 12;
    localparam int          M         = 6;
    localparam int          Q         = 63;
    localparam logic [6:0]  PRIM_POLY = 7'h43;
    localparam logic [12:0] GEN_POLY  = 13'h1539;

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r;
        logic [M-1:0] x;
        r = '0;
        x = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) r = r ^ x;
            x = x[M-1] ? ((x << 1) ^ PRIM_POLY[M-1:0]) : (x << 1);
        end
        return r;
    endfunction

    function automatic logic [M-1:0] alpha_pow(input int e);
        logic [M-1:0] r;
        int           ee;
        ee = e % Q;
        r  = M'(1);
        for (int i = 0; i < Q; i++) begin
            if (i < ee) r = gf_mul(r, M'(2));
        end
        return r;
    endfunction

    // Discrete log by walking the antilog sequence; value for a=0 is unused.
    function automatic logic [M-1:0] gf_log(input logic [M-1:0] a);
        logic [M-1:0] x;
        logic [M-1:0] lg;
        x  = M'(1);
        lg = '0;
        for (int e = 0; e < Q; e++) begin
            if (x == a) lg = M'(e);
            x = gf_mul(x, M'(2));
        end
        return lg;
    endfunction

    function automatic logic [M-1:0] gf_inv(input logic [M-1:0] a);
        if (a == '0) return '0;
        return alpha_pow((Q - int'(gf_log(a))) % Q);
    endfunction

    function automatic logic [M-1:0] gf_cube(input logic [M-1:0] a);
        return gf_mul(gf_mul(a, a), a);
    endfunction

    // Remainder of d(x)*x^12 divided by g(x), shifted in MSB first.
    function automatic logic [P-1:0] calc_parity(input logic [K-1:0] d);
        logic [P-1:0] r;
        logic         fb;
        r = '0;
        for (int i = K - 1; i >= 0; i--) begin
            fb = d[i] ^ r[P-1];
            r  = (r << 1) ^ (fb ? GEN_POLY[P-1:0] : '0);
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bch_32_12_codec_gf64_mul.sv
// ============================================================================
//  Module      : gf64_mul
//  Description : Combinational GF(2^6) multiplier, field polynomial x^6+x+1
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gf64_mul
    import bch_pkg::*;
(
    input  logic [M-1:0] i_a,
    input  logic [M-1:0] i_b,
    output logic [M-1:0] o_y
);

    assign o_y = gf_mul(i_a, i_b);

endmodule

`default_nettype wire

// File: rtl/bch_32_12_codec.sv
// ============================================================================
//  Module      : bch_32_12_codec
//  Description : BCH(44,32) t=2 encoder (1 cycle) and syndrome/Chien decoder
//                (2 cycles), independent fully pipelined paths
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bch_32_12_codec
    import bch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enc_valid,
    input  logic [K-1:0] enc_data,
    output logic         enc_out_valid,
    output logic [P-1:0] enc_parity,
    input  logic         dec_valid,
    input  logic [K-1:0] dec_data,
    input  logic [P-1:0] dec_parity,
    output logic         dec_out_valid,
    output logic [K-1:0] dec_mask,
    output logic         dec_error
);

    logic         r_enc_valid;
    logic [P-1:0] r_enc_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enc_valid  <= 1'b0;
            r_enc_parity <= '0;
        end else begin
            r_enc_valid <= enc_valid;
            if (enc_valid) r_enc_parity <= calc_parity(enc_data);
        end
    end

    assign enc_out_valid = r_enc_valid;
    assign enc_parity    = r_enc_parity;

    // Stage 1: S1 = r(alpha), S3 = r(alpha^3) over all received positions.
    logic [N-1:0] w_rx;
    logic [M-1:0] w_s1;
    logic [M-1:0] w_s3;
    logic         r_v1;
    logic [M-1:0] r_s1;
    logic [M-1:0] r_s3;

    assign w_rx = {dec_data, dec_parity};

    always_comb begin
        w_s1 = '0;
        w_s3 = '0;
        for (int j = 0; j < N; j++) begin
            if (w_rx[j]) begin
                w_s1 = w_s1 ^ alpha_pow(j);
                w_s3 = w_s3 ^ alpha_pow(3 * j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_s1 <= '0;
            r_s3 <= '0;
        end else begin
            r_v1 <= dec_valid;
            if (dec_valid) begin
                r_s1 <= w_s1;
                r_s3 <= w_s3;
            end
        end
    end

    // Stage 2: sigma(x) = 1 + S1 x + ((S3 + S1^3)/S1) x^2, then Chien search.
    logic [M-1:0] w_sigma2;
    logic [N-1:0] w_root;
    logic [M-1:0] w_cnt;
    logic [M-1:0] w_deg;
    logic         w_fail;
    logic         r_v2;
    logic [K-1:0] r_mask;
    logic         r_err;

    gf64_mul u_sigma2 (
        .i_a (r_s3 ^ gf_cube(r_s1)),
        .i_b (gf_inv(r_s1)),
        .o_y (w_sigma2)
    );

    generate
        for (genvar k = 0; k < N; k++) begin : g_chien
            localparam logic [M-1:0] c_inv1 = alpha_pow((Q - k) % Q);
            localparam logic [M-1:0] c_inv2 = alpha_pow((2 * Q - 2 * k) % Q);
            logic [M-1:0] w_t1;
            logic [M-1:0] w_t2;

            gf64_mul u_t1 (.i_a(r_s1),     .i_b(c_inv1), .o_y(w_t1));
            gf64_mul u_t2 (.i_a(w_sigma2), .i_b(c_inv2), .o_y(w_t2));

            assign w_root[k] = ((w_t1 ^ w_t2) == M'(1));
        end
    endgenerate

    // Roots beyond position 43 show up as a short root count.
    always_comb begin
        w_cnt = '0;
        for (int k = 0; k < N; k++) begin
            w_cnt = w_cnt + {{(M-1){1'b0}}, w_root[k]};
        end
        w_deg  = (w_sigma2 != '0) ? M'(2) : M'(1);
        w_fail = 1'b0;
        if (r_s1 == '0) w_fail = (r_s3 != '0);
        else            w_fail = (w_cnt != w_deg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2   <= 1'b0;
            r_mask <= '0;
            r_err  <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_mask <= w_fail ? '0 : w_root[N-1:P];
                r_err  <= w_fail;
            end
        end
    end

    assign dec_out_valid = r_v2;
    assign dec_mask      = r_mask;
    assign dec_error     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bch_32_12_codec.sv
// ============================================================================
//  Module      : tb_bch_32_12_codec
//  Description : Self-checking bench for bch_32_12_codec
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bch_32_12_codec;

    localparam logic [12:0] c_gen = 13'h1539;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enc_valid;
    logic [31:0] enc_data;
    logic        enc_out_valid;
    logic [11:0] enc_parity;
    logic        dec_valid;
    logic [31:0] dec_data;
    logic [11:0] dec_parity;
    logic        dec_out_valid;
    logic [31:0] dec_mask;
    logic        dec_error;

    always #5 clk = ~clk;

    bch_32_12_codec dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enc_valid     (enc_valid),
        .enc_data      (enc_data),
        .enc_out_valid (enc_out_valid),
        .enc_parity    (enc_parity),
        .dec_valid     (dec_valid),
        .dec_data      (dec_data),
        .dec_parity    (dec_parity),
        .dec_out_valid (dec_out_valid),
        .dec_mask      (dec_mask),
        .dec_error     (dec_error)
    );

    typedef struct {
        logic        v;
        logic [11:0] par;
    } enc_exp_t;

    typedef struct {
        logic        v;
        logic [31:0] mask;
        logic        err;
        logic [31:0] rx;
        logic [31:0] orig;
    } dec_exp_t;

    enc_exp_t    eq[$];
    dec_exp_t    dq[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic        s_enc_v;
    logic [31:0] s_enc_d;
    logic        s_dec_v;
    logic [31:0] s_dec_d;
    logic [11:0] s_dec_p;
    dec_exp_t    s_exp;
    logic [11:0] last_par;

    // Long division of d(x)*x^12 by g(x).
    function automatic logic [11:0] ref_parity(input logic [31:0] d);
        logic [43:0] v;
        v = {d, 12'h000};
        for (int b = 43; b >= 12; b--) begin
            if (v[b]) v = v ^ ({31'd0, c_gen} << (b - 12));
        end
        return v[11:0];
    endfunction

    function automatic logic is_codeword(input logic [43:0] w);
        return ref_parity(w[43:12]) == w[11:0];
    endfunction

    // Nearest codeword within distance 2, else uncorrectable: {err, error pattern}.
    function automatic logic [44:0] ref_decode(input logic [43:0] r);
        if (is_codeword(r)) return 45'd0;
        for (int i = 0; i < 44; i++) begin
            logic [43:0] e1;
            e1 = 44'd1 << i;
            if (is_codeword(r ^ e1)) return {1'b0, e1};
        end
        for (int i = 0; i < 44; i++) begin
            for (int j = i + 1; j < 44; j++) begin
                logic [43:0] e2;
                e2 = (44'd1 << i) | (44'd1 << j);
                if (is_codeword(r ^ e2)) return {1'b0, e2};
            end
        end
        return {1'b1, 44'd0};
    endfunction

    function automatic logic [43:0] rand_flips(input int n);
        logic [43:0] e;
        int          pos;
        e = '0;
        for (int i = 0; i < n; i++) begin
            do pos = $urandom_range(0, 43); while (e[pos]);
            e[pos] = 1'b1;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic stage_dec_known(input logic [31:0] orig, input logic [43:0] flips);
        logic [43:0] rx;
        rx      = {orig, ref_parity(orig)} ^ flips;
        s_dec_v = 1'b1;
        s_dec_d = rx[43:12];
        s_dec_p = rx[11:0];
        s_exp   = '{v: 1'b1, mask: flips[43:12], err: 1'b0, rx: rx[43:12], orig: orig};
    endtask

    task automatic stage_dec_model(input logic [31:0] orig, input logic [43:0] flips);
        logic [43:0] rx;
        logic [44:0] res;
        rx      = {orig, ref_parity(orig)} ^ flips;
        res     = ref_decode(rx);
        s_dec_v = 1'b1;
        s_dec_d = rx[43:12];
        s_dec_p = rx[11:0];
        s_exp   = '{v: 1'b1, mask: res[43:12], err: res[44], rx: rx[43:12],
                    orig: rx[43:12] ^ res[43:12]};
    endtask

    // One cycle: check outputs at the negedge, then apply the staged inputs.
    task automatic step();
        enc_exp_t ee;
        dec_exp_t de;
        @(negedge clk);
        if (eq.size() == 1) begin
            ee = eq.pop_front();
            check("enc_out_valid", {31'd0, enc_out_valid}, {31'd0, ee.v});
            check("enc_parity", {20'd0, enc_parity}, {20'd0, ee.par});
        end
        if (dq.size() == 2) begin
            de = dq.pop_front();
            check("dec_out_valid", {31'd0, dec_out_valid}, {31'd0, de.v});
            if (de.v) begin
                check("dec_mask", dec_mask, de.mask);
                check("dec_error", {31'd0, dec_error}, {31'd0, de.err});
                check("dec_corrected", de.rx ^ dec_mask, de.orig);
            end
        end
        enc_valid  = s_enc_v;
        enc_data   = s_enc_d;
        dec_valid  = s_dec_v;
        dec_data   = s_dec_d;
        dec_parity = s_dec_p;
        if (s_enc_v) last_par = ref_parity(s_enc_d);
        eq.push_back('{v: s_enc_v, par: last_par});
        if (s_dec_v) dq.push_back(s_exp);
        else         dq.push_back('{v: 1'b0, mask: 32'd0, err: 1'b0, rx: 32'd0, orig: 32'd0});
        s_enc_v = 1'b0;
        s_enc_d = '0;
        s_dec_v = 1'b0;
        s_dec_d = '0;
        s_dec_p = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_enc_out_valid"}, {31'd0, enc_out_valid}, 32'd0);
        check({tag, "_enc_parity"}, {20'd0, enc_parity}, 32'd0);
        check({tag, "_dec_out_valid"}, {31'd0, dec_out_valid}, 32'd0);
        check({tag, "_dec_mask"}, dec_mask, 32'd0);
        check({tag, "_dec_error"}, {31'd0, dec_error}, 32'd0);
    endtask

    initial begin
        rst_n      = 1'b1;
        enc_valid  = 1'b0;
        enc_data   = '0;
        dec_valid  = 1'b0;
        dec_data   = '0;
        dec_parity = '0;
        s_enc_v    = 1'b0;
        s_enc_d    = '0;
        s_dec_v    = 1'b0;
        s_dec_d    = '0;
        s_dec_p    = '0;
        s_exp      = '{v: 1'b0, mask: 32'd0, err: 1'b0, rx: 32'd0, orig: 32'd0};
        last_par   = '0;
        #1 rst_n = 1'b0;
        #2 check_all_zero("reset");
        step();
        step();
        #2 rst_n = 1'b1;

        // Directed encoder vectors with literal results.
        s_enc_v = 1'b1; s_enc_d = 32'h0000_0001;
        step();
        s_enc_v = 1'b1; s_enc_d = 32'h0000_0002;
        step();
        check("enc_lit_1", {20'd0, enc_parity}, 32'h0000_0539);
        s_enc_v = 1'b1; s_enc_d = 32'h0000_0000;
        stage_dec_known(32'h0000_0000, 44'd0);
        step();
        check("enc_lit_2", {20'd0, enc_parity}, 32'h0000_0A72);
        stage_dec_known(32'h0001_3346, {32'h0001_2000, 12'h000});
        step();
        check("enc_lit_0", {20'd0, enc_parity}, 32'h0000_0000);
        stage_dec_known($urandom, {32'h8000_0000, 12'h000});
        step();
        stage_dec_known($urandom, 44'h000_0000_0001);
        step();
        stage_dec_known($urandom, {32'h0000_0020, 12'h080});
        step();
        step();
        step();

        // Back-to-back stream, 0-2 flips per word, encoder busy in parallel.
        for (int w = 0; w < 100; w++) begin
            stage_dec_known($urandom, rand_flips($urandom_range(0, 2)));
            s_enc_v = ($urandom_range(0, 3) != 0);
            s_enc_d = $urandom;
            step();
        end

        // Heavier corruption, compared against the nearest-codeword model.
        for (int w = 0; w < 12; w++) begin
            stage_dec_model($urandom, rand_flips($urandom_range(3, 5)));
            step();
        end

        // Reset while words are in flight.
        for (int w = 0; w < 3; w++) begin
            stage_dec_known($urandom, rand_flips(1));
            s_enc_v = 1'b1;
            s_enc_d = $urandom;
            step();
        end
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        enc_valid = 1'b0;
        dec_valid = 1'b0;
        eq.delete();
        dq.delete();
        last_par = '0;
        step();
        step();
        step();
        #2 rst_n = 1'b1;
        step();
        step();
        s_enc_v = 1'b1; s_enc_d = 32'h0000_0001;
        stage_dec_known(32'h0001_3346, {32'h0001_2000, 12'h000});
        step();
        for (int w = 0; w < 4; w++) begin
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bch_32_12_codec.md
Name: bch_32_12_codec

Overview:
- Binary BCH(44,32) codec, t=2: the (63,51) code over GF(2^6), shortened to 32 data bits plus 12 parity bits.
- Encoder computes 12 parity bits for a 32-bit word, e.g. PUF enrollment helper data.
- Decoder takes a re-read 32-bit word plus the stored parity and returns a 32-bit error mask and an uncorrectable flag; corrected data = data XOR mask.
- Sits between the PUF response source and key generation; fully pipelined, one word per cycle per path.

Parameters:
- None. Code geometry is fixed by package constants.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- enc_valid  in  1  encoder input qualifier
- enc_data  in  32  word to encode
- enc_out_valid  out  1  enc_parity valid, 1 cycle after enc_valid
- enc_parity  out  12  parity of enc_data
- dec_valid  in  1  decoder input qualifier
- dec_data  in  32  received word
- dec_parity  in  12  stored parity
- dec_out_valid  out  1  decoder outputs valid, 2 cycles after dec_valid
- dec_mask  out  32  error positions within dec_data
- dec_error  out  1  1 = uncorrectable word

Behaviour:
- Field and generator:
  - GF(2^6) uses primitive polynomial x^6+x+1 (0x43); alpha is a root.
  - g(x) = x^12+x^10+x^8+x^5+x^4+x^3+1 (0x1539).
- Codeword mapping:
  - c(x) = d(x)·x^12 + p(x).
  - Data bit i is the coefficient of x^(i+12); parity bit j is the coefficient of x^j.
  - Positions 0..43 are valid.
- Encoder:
  - p(x) = d(x)·x^12 mod g(x), computed combinationally.
  - Registered on enc_valid; enc_out_valid is enc_valid delayed 1 cycle.
  - enc_parity holds its last value when enc_valid is low.
- Decoder stage 1 (registered): syndromes S1 = r(alpha) and S3 = r(alpha^3) over all 44 received bits.
- Decoder stage 2 (registered):
  - S1=0 and S3=0: mask=0, error=0.
  - S1≠0 and S3=S1^3: single error at position log_alpha(S1).
  - S1≠0 otherwise: sigma(x) = 1 + S1·x + ((S3+S1^3)/S1)·x^2. Chien search over positions 0..43; a position k is in error when sigma(alpha^-k)=0.
  - S1=0 and S3≠0: error=1.
  - Root count ≠ sigma degree, or a located position ≥44: error=1.
  - Whenever error=1, mask=0.
- Mask content:
  - dec_mask bit i = 1 when position i+12 is in error.
  - Parity-position errors are corrected implicitly and never reported in the mask.
- Timing:
  - dec_out_valid is dec_valid delayed 2 cycles.
  - Back-to-back inputs are accepted every cycle; there is no backpressure.
  - The encoder and decoder paths are independent and may be active in the same cycle.
- Reset:
  - Every output and pipeline register clears to 0 immediately while rst_n is low.
  - In-flight words are discarded; the first valid output after reset comes from a post-reset input.
- More than 2 errors: behaviour is what the algorithm yields (detect or miscorrect); no additional guarantee.

Decomposition:
- Package bch_pkg:
  - constants N=44, K=32, P=12, M=6, PRIM_POLY=7'h43, GEN_POLY=13'h1539
  - functions: GF(2^6) multiply, inverse (log/antilog tables), cube, alpha-power constant
- One sub-module, gf64_mul: a combinational GF(2^6) multiplier, instanced for the sigma coefficients and the Chien evaluators.

Test Plan:
- Encode 0x00000001 -> enc_parity=0x539 one cycle later. Encode 0x00000002 -> 0xA72. Encode 0x00000000 -> 0x000.
- Decode data 0x00000000 with parity 0x000 -> mask=0x00000000, error=0, dec_out_valid two cycles after dec_valid.
- Double error: encode 0x00013346 to get P; decode 0x00001346 with P -> mask=0x00012000, error=0, data XOR mask = 0x00013346.
- Single errors: flip data bit 31 -> mask=0x80000000. Flip only parity bit 0 -> mask=0, error=0. Flip one data bit and one parity bit -> mask shows the data bit, error=0.
- Streaming: 100 random words, each with 0–2 random flips, on consecutive cycles -> every corrected word equals the original and error=0.
- Assert rst_n low mid-stream -> all outputs 0 immediately. After release, no stale valid appears, and the next input produces correct results at the nominal latency.
